// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter.
package arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_st_t;

  // Increment an index and wrap it modulo size. Size need not be a power of two.
  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned size);
    return (idx + 1 >= size) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_prio_enc.sv
// Rotating priority encoder: picks the first asserted request at or after ptr_i, cyclically.
module rr_prio_enc #(
  parameter int SIZE  = 2,
  parameter int IDX_W = $clog2(SIZE)
) (
  input  logic [SIZE-1:0]  req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] sel_o,
  output logic             any_o
);

  logic [IDX_W:0] k;

  // Scan from the farthest slot back to ptr so the closest request wins.
  always_comb begin
    sel_o = ptr_i;
    k     = '0;
    for (int j = SIZE - 1; j >= 0; j--) begin
      k = {1'b0, ptr_i} + (IDX_W + 1)'(j);
      if (k >= (IDX_W + 1)'(SIZE)) k = k - (IDX_W + 1)'(SIZE);
      if (req_i[k[IDX_W-1:0]]) sel_o = k[IDX_W-1:0];
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/arb_rr.sv
// Round-robin arbiter sharing one valid/ready consumer between SIZE producers;
// the winner's index is prepended to its data, optionally locked until an eot beat.
module arb_rr
  import arb_pkg::*;
#(
  parameter int SIZE    = 2,
  parameter int DIN_W   = 16,
  parameter int EOT_EN  = 0,
  parameter int EOT_POS = 15,
  parameter int IDX_W   = $clog2(SIZE)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [SIZE-1:0]             din_valid_i,
  input  logic [SIZE-1:0][DIN_W-1:0]  din_data_i,
  output logic [SIZE-1:0]             din_ready_o,
  output logic                        dout_valid_o,
  output logic [IDX_W+DIN_W-1:0]      dout_data_o,
  input  logic                        dout_ready_i
);

  arb_st_t          st_q, st_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] lck_q, lck_d;

  logic [IDX_W-1:0] enc_sel;
  logic             enc_any;
  logic [IDX_W-1:0] sel;
  logic [DIN_W-1:0] sel_data;
  logic             hs;
  logic             eot;
  logic             release_grant;

  rr_prio_enc #(
    .SIZE  (SIZE),
    .IDX_W (IDX_W)
  ) u_enc (
    .req_i (din_valid_i),
    .ptr_i (ptr_q),
    .sel_o (enc_sel),
    .any_o (enc_any)
  );

  assign sel           = (st_q == LOCK) ? lck_q : enc_sel;
  assign sel_data      = din_data_i[sel];
  assign dout_valid_o  = (st_q == LOCK) ? din_valid_i[lck_q] : enc_any;
  assign dout_data_o   = {sel, sel_data};
  assign hs            = dout_valid_o & dout_ready_i;
  assign eot           = (EOT_EN != 0) && sel_data[EOT_POS];
  assign release_grant = (EOT_EN == 0) || eot;

  always_comb begin
    for (int i = 0; i < SIZE; i++) begin
      din_ready_o[i] = dout_ready_i & (sel == IDX_W'(i)) & din_valid_i[sel];
    end
  end

  // A stalled IDLE grant is locked too, so dout_data_o cannot change while valid.
  always_comb begin
    st_d  = st_q;
    ptr_d = ptr_q;
    lck_d = lck_q;
    case (st_q)
      IDLE: begin
        if (hs && release_grant) begin
          ptr_d = IDX_W'(next_idx(32'(sel), SIZE));
        end else if (dout_valid_o) begin
          lck_d = sel;
          st_d  = LOCK;
        end
      end
      LOCK: begin
        if (hs && release_grant) begin
          ptr_d = IDX_W'(next_idx(32'(lck_q), SIZE));
          st_d  = IDLE;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q  <= IDLE;
      ptr_q <= '0;
      lck_q <= '0;
    end else begin
      st_q  <= st_d;
      ptr_q <= ptr_d;
      lck_q <= lck_d;
    end
  end

endmodule

// File: tb/tb_arb_rr.sv
// Directed bench for arb_rr: three instances cover plain round-robin, eot locking and a 5-way wrap.
module tb_arb_rr;

  logic clk;
  logic rst;

  // Instance A: SIZE=3, arbitrate every beat
  logic [2:0]       a_valid;
  logic [2:0][15:0] a_data;
  logic [2:0]       a_ready;
  logic             a_dv;
  logic [17:0]      a_dd;
  logic             a_rdy;

  // Instance E: SIZE=3, eot locking on bit 15
  logic [2:0]       e_valid;
  logic [2:0][15:0] e_data;
  logic [2:0]       e_ready;
  logic             e_dv;
  logic [17:0]      e_dd;
  logic             e_rdy;

  // Instance F: SIZE=5, eot locking on bit 15
  logic [4:0]       f_valid;
  logic [4:0][15:0] f_data;
  logic [4:0]       f_ready;
  logic             f_dv;
  logic [18:0]      f_dd;
  logic             f_rdy;

  int n_chk;
  int n_err;

  logic [15:0] tab [3];
  logic [15:0] beat [3];

  arb_rr #(.SIZE(3), .DIN_W(16), .EOT_EN(0), .EOT_POS(15)) u_a (
    .clk(clk), .rst(rst),
    .din_valid_i(a_valid), .din_data_i(a_data), .din_ready_o(a_ready),
    .dout_valid_o(a_dv), .dout_data_o(a_dd), .dout_ready_i(a_rdy)
  );

  arb_rr #(.SIZE(3), .DIN_W(16), .EOT_EN(1), .EOT_POS(15)) u_e (
    .clk(clk), .rst(rst),
    .din_valid_i(e_valid), .din_data_i(e_data), .din_ready_o(e_ready),
    .dout_valid_o(e_dv), .dout_data_o(e_dd), .dout_ready_i(e_rdy)
  );

  arb_rr #(.SIZE(5), .DIN_W(16), .EOT_EN(1), .EOT_POS(15)) u_f (
    .clk(clk), .rst(rst),
    .din_valid_i(f_valid), .din_data_i(f_data), .din_ready_o(f_ready),
    .dout_valid_o(f_dv), .dout_data_o(f_dd), .dout_ready_i(f_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic [1:0] idx, input logic [15:0] d, input logic [2:0] rdy);
    check({tag, ".v"}, 32'(a_dv), 32'd1);
    check({tag, ".d"}, 32'(a_dd), 32'({idx, d}));
    check({tag, ".r"}, 32'(a_ready), 32'(rdy));
  endtask

  task automatic chk_e(input string tag, input logic [1:0] idx, input logic [15:0] d, input logic [2:0] rdy);
    check({tag, ".v"}, 32'(e_dv), 32'd1);
    check({tag, ".d"}, 32'(e_dd), 32'({idx, d}));
    check({tag, ".r"}, 32'(e_ready), 32'(rdy));
  endtask

  task automatic chk_f(input string tag, input logic [2:0] idx, input logic [15:0] d, input logic [4:0] rdy);
    check({tag, ".v"}, 32'(f_dv), 32'd1);
    check({tag, ".d"}, 32'(f_dd), 32'({idx, d}));
    check({tag, ".r"}, 32'(f_ready), 32'(rdy));
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    tab[0] = 16'h00A0; tab[1] = 16'h00B0; tab[2] = 16'h00C0;
    beat[0] = 16'h0001; beat[1] = 16'h0002; beat[2] = 16'h8003;
    rst = 1'b0;
    a_valid = '0; a_data = '0; a_rdy = 1'b0;
    e_valid = '0; e_data = '0; e_rdy = 1'b0;
    f_valid = '0; f_data = '0; f_rdy = 1'b0;

    #3;
    check("rst_a_v", 32'(a_dv), 32'd0);
    check("rst_a_r", 32'(a_ready), 32'd0);
    check("rst_e_v", 32'(e_dv), 32'd0);
    check("rst_f_r", 32'(f_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // All three valid, always ready: 0,1,2,0,1,2
    a_valid = 3'b111;
    a_data[0] = tab[0]; a_data[1] = tab[1]; a_data[2] = tab[2];
    a_rdy = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk_a($sformatf("rr%0d", c), 2'(c % 3), tab[c % 3], 3'(1 << (c % 3)));
      tick();
    end

    // din1 stalled 3 cycles, din0 arrives in cycle 2 and must wait
    a_valid = 3'b010; a_rdy = 1'b0;
    a_data[1] = 16'h1234; a_data[0] = 16'h0055;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) a_valid[0] = 1'b1;
      #1;
      chk_a($sformatf("stall%0d", c), 2'd1, 16'h1234, 3'b000);
      tick();
    end
    a_rdy = 1'b1;
    #1;
    chk_a("stall_go1", 2'd1, 16'h1234, 3'b010);
    tick();
    a_valid = 3'b001;
    #1;
    chk_a("stall_go0", 2'd0, 16'h0055, 3'b001);
    tick();
    a_valid = 3'b000;

    // Idle: nothing valid, ptr must stay at 1
    for (int c = 0; c < 10; c++) begin
      #1;
      check($sformatf("idle%0d.v", c), 32'(a_dv), 32'd0);
      check($sformatf("idle%0d.r", c), 32'(a_ready), 32'd0);
      tick();
    end
    a_valid = 3'b111;
    a_data[0] = tab[0]; a_data[1] = tab[1]; a_data[2] = tab[2];
    for (int c = 0; c < 3; c++) begin
      #1;
      chk_a($sformatf("post_idle%0d", c), 2'((c + 1) % 3), tab[(c + 1) % 3], 3'(1 << ((c + 1) % 3)));
      tick();
    end
    a_valid = 3'b000;

    // eot lock: din0 three beats contiguous while din2 waits
    e_valid = 3'b101; e_data[2] = 16'h8222; e_rdy = 1'b1;
    for (int b = 0; b < 3; b++) begin
      e_data[0] = beat[b];
      #1;
      chk_e($sformatf("eot_b%0d", b), 2'd0, beat[b], 3'b001);
      tick();
    end
    e_valid[0] = 1'b0;
    #1;
    chk_e("eot_din2", 2'd2, 16'h8222, 3'b100);
    tick();
    e_valid = 3'b000;

    // SIZE=5 wrap: grant 4, then ptr=0 beats a still-valid din4
    f_valid = 5'b10000; f_data[4] = 16'h8004; f_data[0] = 16'h8000; f_rdy = 1'b1;
    #1;
    chk_f("wrap4", 3'd4, 16'h8004, 5'b10000);
    tick();
    f_valid = 5'b10001;
    #1;
    chk_f("wrap0", 3'd0, 16'h8000, 5'b00001);
    tick();
    #1;
    chk_f("wrap4b", 3'd4, 16'h8004, 5'b10000);
    tick();
    f_valid = 5'b00000;

    // Async reset in the middle of a locked din3 transaction
    f_valid = 5'b01000; f_data[3] = 16'h0031;
    #1;
    chk_f("lk_b0", 3'd3, 16'h0031, 5'b01000);
    tick();
    f_data[3] = 16'h0032; f_valid = 5'b01001;
    #1;
    chk_f("lk_b1", 3'd3, 16'h0032, 5'b01000);
    #2;
    rst = 1'b0;
    #1;
    chk_f("rst_mid", 3'd0, 16'h8000, 5'b00001);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_f("rst_rel", 3'd0, 16'h8000, 5'b00001);
    tick();
    f_valid[0] = 1'b0; f_data[3] = 16'h8033;
    #1;
    chk_f("rst_din3", 3'd3, 16'h8033, 5'b01000);
    tick();
    f_valid = 5'b00000;
    #1;
    check("end_f_v", 32'(f_dv), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/arb_rr.md
Name: arb_rr

Overview:
- Round-robin arbiter that shares one DTI consumer between SIZE DTI producers; the fan-in counterpart of the broadcast stage.
- Each granted beat is forwarded with the requester index prepended to its data.
- Optionally holds the grant across a multi-beat transaction until an end-of-transaction (eot) beat is transferred.
- Sits in front of any shared resource fed by several pipelines.

Parameters:
- SIZE, 2, number of requesting producers (2..16).
- DIN_W, 16, data width of each din interface.
- EOT_EN, 0, 1 = grant stays locked until a beat with data[EOT_POS]=1 is transferred; 0 = arbitrate every beat.
- EOT_POS, 15, bit position of the eot flag within din data; ignored when EOT_EN=0.
- IDX_W, $clog2(SIZE), width of the index field on dout.

Ports:
- clk, input, 1, clock; all state on rising edge.
- rst, input, 1, asynchronous active-low reset.
- din[SIZE-1:0], dti.consumer, DIN_W data each, requesting producers.
- dout, dti.producer, IDX_W+DIN_W data, arbitrated output; data = {index, din[sel].data}, index in MSBs.

Behaviour:
- State: ptr (IDX_W bits, highest-priority requester), st in {IDLE, LOCK}, lck (IDX_W bits, locked index).
- Reset (rst=0, asynchronous): ptr=0, st=IDLE, lck=0. With no din valid, dout.valid=0 and all din.ready=0.
- Selection in IDLE: sel = first i with din[i].valid, scanning cyclically ptr, ptr+1, ..., ptr+SIZE-1 mod SIZE.
- Selection in LOCK: sel = lck.
- Combinational, zero latency:
  - dout.valid = din[sel].valid (IDLE: any din valid).
  - dout.data = {sel, din[sel].data}.
  - din[i].ready = dout.ready & (i==sel) & din[sel].valid.
  - Non-selected din.ready is always 0.
- Handshake = dout.valid & dout.ready. eot = EOT_EN & din[sel].data[EOT_POS].
- IDLE transitions:
  - handshake & (!EOT_EN | eot): ptr <= (sel+1) mod SIZE; stay IDLE.
  - handshake & EOT_EN & !eot: lck <= sel; st <= LOCK.
  - dout.valid & !dout.ready: lck <= sel; st <= LOCK. Freezes the choice so dout.data stays stable while valid, as DTI requires.
  - no valid: hold.
- LOCK transitions:
  - handshake & (!EOT_EN | eot): ptr <= (lck+1) mod SIZE; st <= IDLE.
  - handshake & EOT_EN & !eot: stay LOCK.
  - no handshake: stay LOCK, even if din[lck].valid drops. That is a producer protocol violation; the block still must not switch.
- ptr wrap: for SIZE not a power of two, ptr = SIZE-1 advances to 0.
- New requests arriving during LOCK are ignored until return to IDLE. No starvation: after a grant, the granted index becomes lowest priority.
- Simultaneous valids at reset exit: index 0 wins first, then 1, and so on.
- Reset mid-transaction: lock dropped, ptr=0. Producers keep valid asserted per DTI and are re-arbitrated.
- No extra pipeline registers; throughput is 1 beat/cycle when dout.ready=1.

Decomposition:
- Package arb_pkg:
  - enum arb_st_t {IDLE, LOCK}.
  - function next_idx(idx, size) for mod-SIZE increment.
- Sub-module rr_prio_enc (SIZE): inputs req[SIZE-1:0] and ptr; outputs sel and any. Pure combinational rotate + priority-encode + unrotate.

Test Plan:
- SIZE=3, EOT_EN=0, dout.ready=1, all three din valid continuously with data 0xA0,0xB0,0xC0 → dout.data index sequence 0,1,2,0,1,2, one beat per cycle.
- SIZE=3, din1 valid only, dout.ready=0 for 3 cycles, then din0 raised in cycle 2 → dout holds {1,din1.data} stable 3 cycles. On ready, din1 transfers first, then din0.
- EOT_EN=1, EOT_POS=15: din0 sends 0x0001,0x0002,0x8003 while din2 is continuously valid → three din0 beats contiguous, then din2 granted. ptr=1 after eot, so din2 is picked over nothing lower.
- SIZE=5, only din4 then din0 valid → after din4 grant, ptr wraps 4→0 and din0 is granted next cycle.
- Assert rst=0 asynchronously mid-LOCK (between non-eot beats) → st=IDLE and ptr=0 immediately. After release with din0 and din3 valid, din0 is granted first.
- No valids for 10 cycles → dout.valid=0, all din.ready=0, ptr unchanged.
